// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader and its RAM.
package instr_mem_loader_pkg;

  localparam int unsigned INSTR_W = 8;
  localparam logic [INSTR_W-1:0] FILL_INSTR_DEFAULT = 8'b00000000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  function automatic int unsigned idx_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/instr_ram.sv
// DEPTH x INSTR_W instruction store: synchronous write, asynchronous read.
module instr_ram
  import instr_mem_loader_pkg::*;
#(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned AW     = idx_w(DEPTH)
) (
  input  logic               CLK,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0]  raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);

  logic [INSTR_W-1:0] mem_q [DEPTH];

  always_ff @(posedge CLK) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Out-of-range reads return zero; the top masks them anyway.
  always_comb begin
    rdata_o = '0;
    if (32'(raddr_i) < DEPTH) rdata_o = mem_q[raddr_i[AW-1:0]];
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction-memory responder with a byte-wide valid/ready program loader;
// holds the CPU while a program is streamed in.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int unsigned         DEPTH      = 32,
  parameter int unsigned         ADDR_W     = 8,
  parameter logic [INSTR_W-1:0]  FILL_INSTR = FILL_INSTR_DEFAULT
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               load_start,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_byte,
  input  logic               load_last,
  output logic               load_ready,
  input  logic [ADDR_W-1:0]  readingAddress,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  prog_len,
  output logic               loaded,
  output logic               cpu_hold,
  output logic               overflow_err
);

  localparam int unsigned     AW      = idx_w(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_e             state_q, state_d;
  logic [ADDR_W:0]    ptr_q, ptr_d;
  logic               loaded_q, loaded_d;
  logic               ovf_q, ovf_d;
  logic               ready_q, hold_q;
  logic               we;
  logic [INSTR_W-1:0] rdata;

  // The write pointer doubles as the program length: it only advances on
  // accepted writes and stops at DEPTH because the overflowing byte is dropped.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    loaded_d = loaded_q;
    ovf_d    = ovf_q;
    we       = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_RUN: begin
        if (load_start) begin
          state_d  = ST_LOAD;
          ptr_d    = '0;
          ovf_d    = 1'b0;
          loaded_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (load_start) begin
          ptr_d    = '0;
          ovf_d    = 1'b0;
          loaded_d = 1'b0;
        end else if (load_valid && ready_q) begin
          if (ptr_q == DEPTH_C) begin
            ovf_d    = 1'b1;
            loaded_d = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            we    = 1'b1;
            ptr_d = ptr_q + 1'b1;
            if (load_last) begin
              state_d  = ST_RUN;
              loaded_d = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      loaded_q <= 1'b0;
      ovf_q    <= 1'b0;
      ready_q  <= 1'b0;
      hold_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      loaded_q <= loaded_d;
      ovf_q    <= ovf_d;
      ready_q  <= (state_d == ST_LOAD);
      hold_q   <= (state_d != ST_RUN);
    end
  end

  instr_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .CLK     (CLK),
    .we_i    (we),
    .waddr_i (ptr_q[AW-1:0]),
    .wdata_i (load_byte),
    .raddr_i (readingAddress),
    .rdata_o (rdata)
  );

  assign instruction  = (loaded_q && ({1'b0, readingAddress} < ptr_q)) ? rdata : FILL_INSTR;
  assign prog_len     = ptr_q[ADDR_W-1:0];
  assign loaded       = loaded_q;
  assign cpu_hold     = hold_q;
  assign load_ready   = ready_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench: default-depth loader plus a DEPTH=4 instance for overflow.
module tb_instr_mem_loader;

  logic       CLK;
  logic       reset;
  // default instance
  logic       load_start, load_valid, load_last, load_ready;
  logic [7:0] load_byte, readingAddress, instruction, prog_len;
  logic       loaded, cpu_hold, overflow_err;
  // DEPTH=4 instance
  logic       d4_start, d4_valid, d4_last, d4_ready;
  logic [7:0] d4_byte, d4_addr, d4_instr, d4_len;
  logic       d4_loaded, d4_hold, d4_ovf;

  int unsigned checks = 0;
  int unsigned passed = 0;

  // Reference model: the accepted program as a byte list plus a loaded flag.
  logic [7:0] q[$];
  logic [7:0] q4[$];
  bit         m_loaded;
  bit         m4_loaded;

  instr_mem_loader dut (
    .CLK(CLK), .reset(reset), .load_start(load_start), .load_valid(load_valid),
    .load_byte(load_byte), .load_last(load_last), .load_ready(load_ready),
    .readingAddress(readingAddress), .instruction(instruction), .prog_len(prog_len),
    .loaded(loaded), .cpu_hold(cpu_hold), .overflow_err(overflow_err)
  );

  instr_mem_loader #(.DEPTH(4)) dut4 (
    .CLK(CLK), .reset(reset), .load_start(d4_start), .load_valid(d4_valid),
    .load_byte(d4_byte), .load_last(d4_last), .load_ready(d4_ready),
    .readingAddress(d4_addr), .instruction(d4_instr), .prog_len(d4_len),
    .loaded(d4_loaded), .cpu_hold(d4_hold), .overflow_err(d4_ovf)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] exp_fetch(input int unsigned a);
    return (m_loaded && a < q.size()) ? q[a] : 8'h00;
  endfunction

  function automatic logic [7:0] exp_fetch4(input int unsigned a);
    return (m4_loaded && a < q4.size()) ? q4[a] : 8'h00;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    {load_start, load_valid, load_last} = '0;
    {d4_start, d4_valid, d4_last} = '0;
    load_byte = '0; d4_byte = '0; readingAddress = '0; d4_addr = '0;
    q.delete(); q4.delete(); m_loaded = 0; m4_loaded = 0;
    #50;
    checks++; if (load_ready !== 1'b0) $display("FAIL reset_ready got=%0b exp=0", load_ready); else passed++;
    checks++; if (prog_len !== 8'd0) $display("FAIL reset_len got=%0d exp=0", prog_len); else passed++;
    checks++; if (loaded !== 1'b0) $display("FAIL reset_loaded got=%0b exp=0", loaded); else passed++;
    checks++; if (cpu_hold !== 1'b1) $display("FAIL reset_hold got=%0b exp=1", cpu_hold); else passed++;
    checks++; if (overflow_err !== 1'b0) $display("FAIL reset_ovf got=%0b exp=0", overflow_err); else passed++;
    checks++; if (instruction !== 8'h00) $display("FAIL reset_instr got=%h exp=00", instruction); else passed++;
    #3 reset = 1'b1;
    tick();
  endtask

  task automatic test_idle_ignore();
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_byte = 8'($urandom); load_last = 1'($urandom);
      tick();
    end
    load_valid = 1'b0; load_last = 1'b0;
    checks++; if (prog_len !== 8'd0) $display("FAIL idle_len got=%0d exp=0", prog_len); else passed++;
    checks++; if (loaded !== 1'b0) $display("FAIL idle_loaded got=%0b exp=0", loaded); else passed++;
    checks++; if (cpu_hold !== 1'b1) $display("FAIL idle_hold got=%0b exp=1", cpu_hold); else passed++;
  endtask

  task automatic test_basic();
    logic [7:0] pat [4];
    logic [7:0] b;
    pat = '{8'h44, 8'h49, 8'h19, 8'h84};
    load_start = 1'b1; tick(); load_start = 1'b0;
    q.delete(); m_loaded = 0;
    checks++; if (load_ready !== 1'b1) $display("FAIL basic_ready got=%0b exp=1", load_ready); else passed++;
    for (int i = 0; i < 21; i++) begin
      b = (i == 20) ? 8'hC3 : pat[i % 4];
      load_valid = 1'b1; load_byte = b; load_last = (i == 20);
      tick();
      q.push_back(b);
    end
    load_valid = 1'b0; load_last = 1'b0; m_loaded = 1;
    checks++; if (loaded !== 1'b1) $display("FAIL basic_loaded got=%0b exp=1", loaded); else passed++;
    checks++; if (prog_len !== 8'd21) $display("FAIL basic_len got=%0d exp=21", prog_len); else passed++;
    checks++; if (cpu_hold !== 1'b0) $display("FAIL basic_hold got=%0b exp=0", cpu_hold); else passed++;
    checks++; if (load_ready !== 1'b0) $display("FAIL basic_ready_run got=%0b exp=0", load_ready); else passed++;
    for (int unsigned a = 0; a <= 21; a++) begin
      readingAddress = 8'(a); #1;
      checks++;
      if (instruction !== exp_fetch(a))
        $display("FAIL basic_fetch addr=%0d got=%h exp=%h", a, instruction, exp_fetch(a));
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    int unsigned n, sent, cyc;
    bit v;
    load_start = 1'b1; tick(); load_start = 1'b0;
    q.delete(); m_loaded = 0;
    n = $urandom_range(5, 30); sent = 0; cyc = 0;
    while (sent < n && cyc < 500) begin
      v = 1'($urandom_range(0, 1));
      load_valid = v; load_byte = 8'($urandom);
      load_last = v ? (sent == n - 1) : 1'($urandom);
      checks++; if (load_ready !== 1'b1) $display("FAIL bp_ready cyc=%0d got=%0b exp=1", cyc, load_ready); else passed++;
      tick();
      if (v) begin q.push_back(load_byte); sent++; end
      cyc++;
    end
    load_valid = 1'b0; load_last = 1'b0; m_loaded = 1;
    checks++; if (sent != n) $display("FAIL bp_budget got=%0d exp=%0d", sent, n); else passed++;
    checks++; if (prog_len !== 8'(n)) $display("FAIL bp_len got=%0d exp=%0d", prog_len, n); else passed++;
    checks++; if (loaded !== 1'b1) $display("FAIL bp_loaded got=%0b exp=1", loaded); else passed++;
    for (int unsigned a = 0; a < 40; a++) begin
      readingAddress = 8'(a); #1;
      checks++;
      if (instruction !== exp_fetch(a))
        $display("FAIL bp_fetch addr=%0d got=%h exp=%h", a, instruction, exp_fetch(a));
      else passed++;
    end
    readingAddress = 8'hFF; #1;
    checks++; if (instruction !== 8'h00) $display("FAIL bp_fetch_ff got=%h exp=00", instruction); else passed++;
  endtask

  task automatic test_reload();
    load_start = 1'b1; tick(); load_start = 1'b0;
    q.delete(); m_loaded = 0;
    readingAddress = 8'd0; #1;
    checks++; if (cpu_hold !== 1'b1) $display("FAIL reload_hold got=%0b exp=1", cpu_hold); else passed++;
    checks++; if (instruction !== 8'h00) $display("FAIL reload_instr got=%h exp=00", instruction); else passed++;
    load_valid = 1'b1; load_byte = 8'hAA; load_last = 1'b0; tick(); q.push_back(8'hAA);
    checks++; if (instruction !== 8'h00) $display("FAIL reload_instr2 got=%h exp=00", instruction); else passed++;
    checks++; if (cpu_hold !== 1'b1) $display("FAIL reload_hold2 got=%0b exp=1", cpu_hold); else passed++;
    load_byte = 8'h55; load_last = 1'b1; tick(); q.push_back(8'h55);
    load_valid = 1'b0; load_last = 1'b0; m_loaded = 1;
    checks++; if (prog_len !== 8'd2) $display("FAIL reload_len got=%0d exp=2", prog_len); else passed++;
    for (int unsigned a = 0; a < 3; a++) begin
      readingAddress = 8'(a); #1;
      checks++;
      if (instruction !== exp_fetch(a))
        $display("FAIL reload_fetch addr=%0d got=%h exp=%h", a, instruction, exp_fetch(a));
      else passed++;
    end
  endtask

  task automatic test_run_ignore();
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_byte = 8'($urandom); load_last = 1'($urandom);
      tick();
    end
    load_valid = 1'b0; load_last = 1'b0;
    checks++; if (prog_len !== 8'(q.size())) $display("FAIL run_ign_len got=%0d exp=%0d", prog_len, q.size()); else passed++;
    for (int unsigned a = 0; a < 3; a++) begin
      readingAddress = 8'(a); #1;
      checks++;
      if (instruction !== exp_fetch(a))
        $display("FAIL run_ign_fetch addr=%0d got=%h exp=%h", a, instruction, exp_fetch(a));
      else passed++;
    end
  endtask

  task automatic test_restart();
    load_start = 1'b1; tick(); load_start = 1'b0;
    q.delete(); m_loaded = 0;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1; load_byte = 8'($urandom); load_last = 1'b0; tick();
    end
    load_start = 1'b1; load_valid = 1'b1; load_byte = 8'hFF; load_last = 1'b1;
    tick();
    load_start = 1'b0;
    checks++; if (prog_len !== 8'd0) $display("FAIL restart_len got=%0d exp=0", prog_len); else passed++;
    checks++; if (load_ready !== 1'b1) $display("FAIL restart_ready got=%0b exp=1", load_ready); else passed++;
    checks++; if (loaded !== 1'b0) $display("FAIL restart_loaded got=%0b exp=0", loaded); else passed++;
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1; load_byte = 8'($urandom_range(0, 254)); load_last = (i == 1);
      tick();
      q.push_back(load_byte);
    end
    load_valid = 1'b0; load_last = 1'b0; m_loaded = 1;
    checks++; if (prog_len !== 8'd2) $display("FAIL restart_len2 got=%0d exp=2", prog_len); else passed++;
    for (int unsigned a = 0; a < 4; a++) begin
      readingAddress = 8'(a); #1;
      checks++;
      if (instruction !== exp_fetch(a))
        $display("FAIL restart_fetch addr=%0d got=%h exp=%h", a, instruction, exp_fetch(a));
      else passed++;
    end
  endtask

  task automatic test_overflow();
    d4_start = 1'b1; tick(); d4_start = 1'b0;
    q4.delete(); m4_loaded = 0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (d4_ready !== 1'b1) $display("FAIL ovf_ready i=%0d got=%0b exp=1", i, d4_ready); else passed++;
      d4_valid = 1'b1; d4_byte = 8'($urandom); d4_last = 1'b0;
      tick();
      if (i == 3) begin
        checks++; if (d4_len !== 8'd4) $display("FAIL ovf_len4 got=%0d exp=4", d4_len); else passed++;
        checks++; if (d4_ovf !== 1'b0) $display("FAIL ovf_early got=%0b exp=0", d4_ovf); else passed++;
      end
    end
    d4_valid = 1'b0;
    checks++; if (d4_ovf !== 1'b1) $display("FAIL ovf_flag got=%0b exp=1", d4_ovf); else passed++;
    checks++; if (d4_loaded !== 1'b0) $display("FAIL ovf_loaded got=%0b exp=0", d4_loaded); else passed++;
    checks++; if (d4_hold !== 1'b1) $display("FAIL ovf_hold got=%0b exp=1", d4_hold); else passed++;
    checks++; if (d4_ready !== 1'b0) $display("FAIL ovf_idle_ready got=%0b exp=0", d4_ready); else passed++;
    checks++; if (d4_len !== 8'd4) $display("FAIL ovf_len_sat got=%0d exp=4", d4_len); else passed++;
    for (int unsigned a = 0; a < 8; a++) begin
      d4_addr = 8'(a); #1;
      checks++; if (d4_instr !== 8'h00) $display("FAIL ovf_fetch addr=%0d got=%h exp=00", a, d4_instr); else passed++;
    end
    tick();
    checks++; if (d4_ovf !== 1'b1) $display("FAIL ovf_sticky got=%0b exp=1", d4_ovf); else passed++;
    // exactly DEPTH bytes with last must load cleanly
    d4_start = 1'b1; tick(); d4_start = 1'b0;
    checks++; if (d4_ovf !== 1'b0) $display("FAIL ovf_clear got=%0b exp=0", d4_ovf); else passed++;
    for (int i = 0; i < 4; i++) begin
      d4_valid = 1'b1; d4_byte = 8'($urandom); d4_last = (i == 3);
      tick();
      q4.push_back(d4_byte);
    end
    d4_valid = 1'b0; d4_last = 1'b0; m4_loaded = 1;
    checks++; if (d4_loaded !== 1'b1) $display("FAIL full_loaded got=%0b exp=1", d4_loaded); else passed++;
    checks++; if (d4_ovf !== 1'b0) $display("FAIL full_ovf got=%0b exp=0", d4_ovf); else passed++;
    for (int unsigned a = 0; a < 8; a++) begin
      d4_addr = 8'(a); #1;
      checks++;
      if (d4_instr !== exp_fetch4(a))
        $display("FAIL full_fetch addr=%0d got=%h exp=%h", a, d4_instr, exp_fetch4(a));
      else passed++;
    end
  endtask

  task automatic test_reset_mid_load();
    load_start = 1'b1; tick(); load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1; load_byte = 8'($urandom); load_last = 1'b0; tick();
    end
    load_valid = 1'b0;
    #2 reset = 1'b0;
    readingAddress = 8'd0;
    #1;
    checks++; if (load_ready !== 1'b0) $display("FAIL rstmid_ready got=%0b exp=0", load_ready); else passed++;
    checks++; if (prog_len !== 8'd0) $display("FAIL rstmid_len got=%0d exp=0", prog_len); else passed++;
    checks++; if (loaded !== 1'b0) $display("FAIL rstmid_loaded got=%0b exp=0", loaded); else passed++;
    checks++; if (cpu_hold !== 1'b1) $display("FAIL rstmid_hold got=%0b exp=1", cpu_hold); else passed++;
    checks++; if (overflow_err !== 1'b0) $display("FAIL rstmid_ovf got=%0b exp=0", overflow_err); else passed++;
    checks++; if (instruction !== 8'h00) $display("FAIL rstmid_instr got=%h exp=00", instruction); else passed++;
    #2 reset = 1'b1;
    tick();
    checks++; if (load_ready !== 1'b0) $display("FAIL rstmid_post_ready got=%0b exp=0", load_ready); else passed++;
    checks++; if (instruction !== 8'h00) $display("FAIL rstmid_post_instr got=%h exp=00", instruction); else passed++;
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_basic();
    test_backpressure();
    test_reload();
    test_run_ignore();
    test_restart();
    test_overflow();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
